// File: rtl/clock_divider_prog_if.sv
// ============================================================================
// clock_divider_prog_if : control/status bundle for the programmable divider
// Revision: 1.0
// ============================================================================
`default_nettype none

interface clock_divider_prog_if #(
  parameter int WIDTH = 32
);
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] div_in;
  logic [WIDTH-1:0] high_in;
  logic             mode_in;
  logic             clk_out;
  logic             tick;
  logic             pending;

  modport master (
    output enable, load, div_in, high_in, mode_in,
    input  clk_out, tick, pending
  );

  modport slave (
    input  enable, load, div_in, high_in, mode_in,
    output clk_out, tick, pending
  );
endinterface

`default_nettype wire

// File: rtl/clock_divider_prog.sv
// ============================================================================
// clock_divider_prog : runtime-programmable clock / tick divider with shadow
//                      reprogramming at period boundaries.
// Optional: CLKDIV_CNT_OUT_EN adds the cnt_out port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module clock_divider_prog #(
  parameter int          WIDTH        = 32,
  parameter int unsigned DIV_DEFAULT  = 25000000,
  parameter int unsigned HIGH_DEFAULT = 12500000
) (
  input  wire logic         clk,
  input  wire logic         rst,
`ifdef CLKDIV_CNT_OUT_EN
  output logic [WIDTH-1:0]  cnt_out,
`endif
  clock_divider_prog_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_r, high_r, div_sh, high_sh;
  logic             mode_r, mode_sh;
  logic             pending_r, clk_out_r, tick_r;

  logic [WIDTH-1:0] period, cnt_nxt, div_nxt, high_nxt;
  logic             mode_nxt, pending_nxt, run_nxt, last;

  always_comb begin
    if (mode_r)
      period = (div_r == '0) ? WIDTH'(1) : div_r;
    else
      period = (div_r < WIDTH'(2)) ? WIDTH'(2) : div_r;
    last        = (cnt == period - WIDTH'(1));
    div_nxt     = div_r;
    high_nxt    = high_r;
    mode_nxt    = mode_r;
    pending_nxt = pending_r;
    run_nxt     = bus.enable;
    cnt_nxt     = '0;
    if (state == IDLE) begin
      if (bus.load) begin
        div_nxt     = bus.div_in;
        high_nxt    = bus.high_in;
        mode_nxt    = bus.mode_in;
        pending_nxt = 1'b0;
      end else if (bus.enable && pending_r) begin
        div_nxt     = div_sh;
        high_nxt    = high_sh;
        mode_nxt    = mode_sh;
        pending_nxt = 1'b0;
      end
    end else if (bus.enable && last) begin
      // Period boundary: a load arriving right now beats the older shadow.
      if (bus.load) begin
        div_nxt     = bus.div_in;
        high_nxt    = bus.high_in;
        mode_nxt    = bus.mode_in;
        pending_nxt = 1'b0;
      end else if (pending_r) begin
        div_nxt     = div_sh;
        high_nxt    = high_sh;
        mode_nxt    = mode_sh;
        pending_nxt = 1'b0;
      end
    end else begin
      if (bus.enable)
        cnt_nxt = cnt + WIDTH'(1);
      if (bus.load)
        pending_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      div_r     <= WIDTH'(DIV_DEFAULT);
      high_r    <= WIDTH'(HIGH_DEFAULT);
      mode_r    <= 1'b0;
      div_sh    <= '0;
      high_sh   <= '0;
      mode_sh   <= 1'b0;
      pending_r <= 1'b0;
      clk_out_r <= 1'b0;
      tick_r    <= 1'b0;
    end else begin
      state     <= run_nxt ? RUN : IDLE;
      cnt       <= cnt_nxt;
      div_r     <= div_nxt;
      high_r    <= high_nxt;
      mode_r    <= mode_nxt;
      pending_r <= pending_nxt;
      if (bus.load) begin
        div_sh  <= bus.div_in;
        high_sh <= bus.high_in;
        mode_sh <= bus.mode_in;
      end
      // Outputs are registered from next-cycle values so they align with cnt.
      tick_r    <= run_nxt && (cnt_nxt == '0);
      clk_out_r <= run_nxt && (mode_nxt ? (cnt_nxt == '0) : (cnt_nxt < high_nxt));
    end
  end

  assign bus.clk_out = clk_out_r;
  assign bus.tick    = tick_r;
  assign bus.pending = pending_r;

`ifdef CLKDIV_CNT_OUT_EN
  assign cnt_out = cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clock_divider_prog.sv
// ============================================================================
// tb_clock_divider_prog : vector table, corner sequences and random traffic
//                         checked against a period-level behavioural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_clock_divider_prog;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clock_divider_prog_if #(.WIDTH(W)) bus ();
`ifdef CLKDIV_CNT_OUT_EN
  logic [W-1:0] cnt_out;
`endif

  clock_divider_prog #(
    .WIDTH(W), .DIV_DEFAULT(10), .HIGH_DEFAULT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef CLKDIV_CNT_OUT_EN
    .cnt_out(cnt_out),
`endif
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a running flag, position within the period, and the programmed values.
  bit m_run, m_mode, s_mode, m_pend;
  int m_pos, m_div, m_high, s_div, s_high;

  function automatic int per();
    if (m_mode) return (m_div < 1) ? 1 : m_div;
    return (m_div < 2) ? 2 : m_div;
  endfunction

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_div = 10; m_high = 3; m_mode = 0;
    s_div = 0; s_high = 0; s_mode = 0; m_pend = 0;
  endtask

  task automatic model_step(bit en, bit ld, int d, int h, bit md);
    if (!m_run) begin
      if (ld) begin
        m_div = d; m_high = h; m_mode = md; m_pend = 0;
      end else if (en && m_pend) begin
        m_div = s_div; m_high = s_high; m_mode = s_mode; m_pend = 0;
      end
      m_pos = 0;
      m_run = en;
    end else if (!en) begin
      m_run = 0; m_pos = 0;
      if (ld) m_pend = 1;
    end else if (m_pos == per() - 1) begin
      if (ld) begin
        m_div = d; m_high = h; m_mode = md;
      end else if (m_pend) begin
        m_div = s_div; m_high = s_high; m_mode = s_mode;
      end
      m_pend = 0;
      m_pos  = 0;
    end else begin
      m_pos++;
      if (ld) m_pend = 1;
    end
    if (ld) begin
      s_div = d; s_high = h; s_mode = md;
    end
  endtask

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  task automatic drive(bit r, bit en, bit ld, int d, int h, bit md);
    bit e_tick, e_clk;
    rst = r; bus.enable = en; bus.load = ld;
    bus.div_in = W'(d); bus.high_in = W'(h); bus.mode_in = md;
    @(posedge clk);
    if (r) model_reset();
    else   model_step(en, ld, d, h, md);
    #1;
    e_tick = m_run && (m_pos == 0);
    e_clk  = m_run && (m_mode ? (m_pos == 0) : (m_pos < m_high));
    chk("model_tick", int'(bus.tick), int'(e_tick));
    chk("model_clk_out", int'(bus.clk_out), int'(e_clk));
    chk("model_pending", int'(bus.pending), int'(m_pend));
`ifdef CLKDIV_CNT_OUT_EN
    chk("model_cnt_out", int'(cnt_out), m_pos);
`endif
  endtask

  task automatic expect_out(string name, bit c, bit t, bit p);
    chk({name, "_clk_out"}, int'(bus.clk_out), int'(c));
    chk({name, "_tick"}, int'(bus.tick), int'(t));
    chk({name, "_pending"}, int'(bus.pending), int'(p));
  endtask

  task automatic run_until_pos(int pos);
    int n = 0;
    while (!(m_run && !m_pend && m_pos == pos)) begin
      drive(0, 1, 0, 0, 0, 0);
      n++;
      if (n > 200) begin
        fail_now("run_until_pos");
        return;
      end
    end
  endtask

  typedef struct {
    bit r, en, ld;
    int d, h;
    bit md;
    bit e_clk, e_tick, e_pend;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int ticks;
    model_reset();
    bus.enable = 0; bus.load = 0; bus.div_in = '0; bus.high_in = '0; bus.mode_in = 0;

    // Defaults 10/3, then reprogram to 4/2 while cnt==5.
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 1, 1, 0};
    tbl[2]  = '{0, 1, 0, 0, 0, 0, 1, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 0, 0, 1, 0, 0};
    tbl[4]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 1, 1, 4, 2, 0, 0, 0, 1};
    tbl[8]  = '{0, 1, 0, 0, 0, 0, 0, 0, 1};
    tbl[9]  = '{0, 1, 0, 0, 0, 0, 0, 0, 1};
    tbl[10] = '{0, 1, 0, 0, 0, 0, 0, 0, 1};
    tbl[11] = '{0, 1, 0, 0, 0, 0, 1, 1, 0};
    tbl[12] = '{0, 1, 0, 0, 0, 0, 1, 0, 0};
    tbl[13] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[14] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[15] = '{0, 1, 0, 0, 0, 0, 1, 1, 0};
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].r, tbl[i].en, tbl[i].ld, tbl[i].d, tbl[i].h, tbl[i].md);
      expect_out($sformatf("vec%0d", i), tbl[i].e_clk, tbl[i].e_tick, tbl[i].e_pend);
    end

    // Tick mode, P=1: continuous 1s.
    drive(0, 1, 1, 1, 0, 1);
    run_until_pos(0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 0, 0);
      expect_out("tick_p1", 1, 1, 0);
    end
    // div_in=0 clamps to P=1; every cycle is a boundary so pending never rises.
    drive(0, 1, 1, 0, 0, 1);
    expect_out("tick_div0_load", 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 0, 0);
      expect_out("tick_div0", 1, 1, 0);
    end

    // Clock mode, high=0: constant low, ticks every 5.
    drive(0, 1, 1, 5, 0, 0);
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, 0, 0, 0);
      chk("high0_clk_out", int'(bus.clk_out), 0);
      ticks += int'(bus.tick);
    end
    chk("high0_tick_count", ticks, 2);

    // high >= P: constant high.
    drive(0, 1, 1, 10, 20, 0);
    run_until_pos(0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, 0, 0, 0);
      chk("high20_clk_out", int'(bus.clk_out), 1);
    end

    // div_in=1 in clock mode clamps to P=2.
    drive(0, 1, 1, 1, 1, 0);
    run_until_pos(0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 0, 0);
      expect_out("p2", i % 2 == 1, i % 2 == 1, 0);
    end

    // Enable drop at cnt=2, re-enable after 5 idle cycles.
    drive(0, 1, 1, 10, 3, 0);
    run_until_pos(2);
    drive(0, 0, 0, 0, 0, 0);
    expect_out("drop", 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    expect_out("reenable", 1, 1, 0);
    for (int i = 0; i < 10; i++) drive(0, 1, 0, 0, 0, 0);
    expect_out("reenable_next_period", 1, 1, 0);

    // Reset mid-period with a pending shadow.
    run_until_pos(4);
    drive(0, 1, 1, 6, 1, 0);
    expect_out("pend_before_rst", 0, 0, 1);
    drive(0, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    expect_out("rst_mid", 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    expect_out("rst_release", 1, 1, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    expect_out("rst_defaults_cnt3", 0, 0, 0);

    // Load coincident with enable drop: held in the shadow until re-enable.
    drive(0, 0, 1, 3, 1, 0);
    expect_out("load_drop", 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    expect_out("load_drop_run", 1, 1, 0);
    drive(0, 1, 0, 0, 0, 0);
    expect_out("load_drop_c1", 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    expect_out("load_drop_wrap", 1, 1, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 19) != 0,
            $urandom_range(0, 7) == 0, int'($urandom_range(0, 12)),
            int'($urandom_range(0, 14)), $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
Runtime-programmable clock divider, parametrised in counter width. Generates a divided clock with programmable period and duty cycle, or a one-cycle tick train. Carries a per-period-start tick strobe and shadow-register reprogramming applied glitch-free at period boundaries. Drop-in upgrade for display-multiplex and seconds-tick generation in the digital clock design.

Parameters:
WIDTH, 32, width of period/high counters and programming inputs
DIV_DEFAULT, 25000000, reset period in clk cycles
HIGH_DEFAULT, 12500000, reset high-time in clk cycles (clock mode)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
enable  in  1  run request; 0 forces idle
load  in  1  one-cycle strobe; capture div_in/high_in/mode_in
div_in  in  WIDTH  requested period in clk cycles
high_in  in  WIDTH  requested high-time in clk cycles
mode_in  in  1  0 = clock mode, 1 = tick mode
clk_out  out  1  divided clock (registered)
tick  out  1  one-cycle strobe, first cycle of each period (registered)
pending  out  1  shadow values captured, not yet applied

Behaviour:
- One clock (clk); reset synchronous, active-high (rst).
- Reset: div_r=DIV_DEFAULT, high_r=HIGH_DEFAULT, mode_r=0, shadow cleared, state IDLE, cnt=0, clk_out=0, tick=0, pending=0. rst mid-period aborts immediately; a pending shadow is discarded.
- States: IDLE, RUN.
- IDLE: cnt=0, clk_out=0, tick=0. When enable=1 is sampled, go to RUN; the first period starts the next cycle (1-cycle latency).
- RUN: cnt steps 0..P-1 and wraps to 0.
  - Effective period P = max(div_r,2) in clock mode, max(div_r,1) in tick mode.
  - tick=1 in every cycle where cnt==0.
  - Clock mode: clk_out=1 while cnt<high_r. high_r=0 gives constant 0; high_r>=P gives constant 1.
  - Tick mode: clk_out=tick. With P=1, tick is continuously 1.
- enable=0 sampled in RUN: next cycle IDLE with cnt=0, clk_out=0, tick=0. The partial period is abandoned; pending and shadow are retained.
- Load, general: load=1 captures div_in/high_in/mode_in into the shadow.
- Load in IDLE: values are written straight to div_r/high_r/mode_r; pending stays 0.
- Load in RUN: pending=1 from the next cycle. The shadow transfers to the active registers in the last cycle of the current period (cnt==P-1); pending clears in the same transfer. The next period uses the new values.
- Load in RUN sampled while cnt==P-1: applied at that boundary; pending never rises.
- Second load while pending: overwrites the shadow (last wins); still applied at the next boundary.
- Load and enable-drop in the same cycle: load is captured to the shadow; it applies on the next IDLE→RUN transition, and pending then clears.
- Arithmetic: unsigned WIDTH-bit counters and comparisons; no wrap beyond P-1.

Optional Feature:
CLKDIV_CNT_OUT_EN
- Defined: adds output port cnt_out (out, WIDTH), the current cnt value; 0 in IDLE and during reset.
- Undefined: port and logic absent; otherwise identical behaviour.

Test Plan:
- Parameters DIV_DEFAULT=10, HIGH_DEFAULT=3; rst then enable=1 -> clk_out high 3 cycles, low 7 cycles, repeating; tick every 10 cycles coincident with the clk_out rise; first rise 1 cycle after enable sampled.
- load div_in=4, high_in=2, mode_in=0 at cnt=5 -> pending=1 until cnt==9; next period is 2 high / 2 low; pending=0 from then on.
- load mode_in=1, div_in=1 -> after boundary, tick and clk_out continuously 1; load div_in=0 -> same (P clamps to 1).
- Clock mode: high_in=0 -> clk_out constant 0, tick still every P; high_in=20 with div_in=10 -> clk_out constant 1; div_in=1 -> P=2, period of 2 cycles.
- enable drop at cnt=2, then re-enable 5 cycles later -> outputs 0 the cycle after the drop; full fresh period starts 1 cycle after re-enable.
- rst asserted mid-period with pending=1 -> next cycle all outputs 0, pending=0; with enable held, timing restarts from DIV_DEFAULT/HIGH_DEFAULT one cycle after rst releases.
